// File: rtl/clock_setup_ctrl_if.sv
// Button inputs and counter-control outputs of the clock setup sequencer.
// The master modport is the side that drives the buttons and watches the controls.
interface clock_setup_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       display;
  logic [5:0] setup_n;
  logic [2:0] field_sel;
  logic       inc_dec;
  logic       tick;
  logic       blink;

  modport master (
    output btn_mode, btn_up, btn_down,
    input  display, setup_n, field_sel, inc_dec, tick, blink
  );

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output display, setup_n, field_sel, inc_dec, tick, blink
  );
endinterface

// File: rtl/clock_setup_ctrl.sv
// Front-panel sequencer for the century clock's time-field counters.
// Steps through RUN and the six SET states on mode presses, turns up/down
// presses into single-cycle adjust ticks with press-and-hold auto-repeat,
// falls back to RUN after an idle timeout and blinks the edited field.
module clock_setup_ctrl #(
  parameter int HOLD_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int TIMEOUT       = 500_000_000,
  parameter int BLINK_HALF    = 12_500_000
) (
  input logic          clk,
  input logic          rst_n,
  clock_setup_ctrl_if.slave bus
);

  localparam int RPT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX);
  localparam int TW      = $clog2(TIMEOUT);
  localparam int BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [RW-1:0] HOLD_LAST  = RW'(HOLD_DELAY - 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_SEC  = 3'd1,
    SET_MIN  = 3'd2,
    SET_HOUR = 3'd3,
    SET_DAY  = 3'd4,
    SET_MON  = 3'd5,
    SET_YEAR = 3'd6
  } state_t;

  state_t        state, nxt_state;
  logic          mode_q, up_q, down_q;
  logic          act_up, act_down, repeating;
  logic [RW-1:0] rep_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] blink_cnt;

  logic mode_rise, up_rise, down_rise;
  logic in_set, tmo_hit, both;
  logic press_up, press_down, hold_up, hold_down;
  logic rep_last, abort, tick_nxt;

  // Mode button walks the fields in order and wraps back to RUN.
  function automatic state_t advance(input state_t s);
    case (s)
      RUN:      return SET_SEC;
      SET_SEC:  return SET_MIN;
      SET_MIN:  return SET_HOUR;
      SET_HOUR: return SET_DAY;
      SET_DAY:  return SET_MON;
      SET_MON:  return SET_YEAR;
      default:  return RUN;
    endcase
  endfunction

  // Active-low enable for the counter being edited; none in RUN.
  function automatic logic [5:0] field_enable_n(input state_t s);
    case (s)
      SET_SEC:  return 6'b111110;
      SET_MIN:  return 6'b111101;
      SET_HOUR: return 6'b111011;
      SET_DAY:  return 6'b110111;
      SET_MON:  return 6'b101111;
      SET_YEAR: return 6'b011111;
      default:  return 6'b111111;
    endcase
  endfunction

  // Edge detection, press/hold qualification and next-state selection.
  always_comb begin
    mode_rise  = bus.btn_mode & ~mode_q;
    up_rise    = bus.btn_up   & ~up_q;
    down_rise  = bus.btn_down & ~down_q;
    in_set     = (state != RUN);
    tmo_hit    = in_set && (tmo_cnt == TMO_LAST);
    both       = bus.btn_up & bus.btn_down;
    press_up   = up_rise   & ~bus.btn_down;
    press_down = down_rise & ~bus.btn_up;
    hold_up    = act_up   & bus.btn_up   & ~bus.btn_down;
    hold_down  = act_down & bus.btn_down & ~bus.btn_up;
    // First repeat waits the long hold delay, later ones the shorter period.
    rep_last   = repeating ? (rep_cnt == RPT_LAST) : (rep_cnt == HOLD_LAST);
    // Mode presses and timeouts take priority over any adjust activity.
    abort      = ~in_set | mode_rise | tmo_hit | both;
    tick_nxt   = ~abort & (press_up | press_down | ((hold_up | hold_down) & rep_last));
    if (mode_rise)    nxt_state = advance(state);
    else if (tmo_hit) nxt_state = RUN;
    else              nxt_state = state;
  end

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      mode_q        <= 1'b0;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      act_up        <= 1'b0;
      act_down      <= 1'b0;
      repeating     <= 1'b0;
      rep_cnt       <= '0;
      tmo_cnt       <= '0;
      blink_cnt     <= '0;
      bus.display   <= 1'b0;
      bus.setup_n   <= 6'b111111;
      bus.field_sel <= 3'd0;
      bus.tick      <= 1'b0;
      bus.inc_dec   <= 1'b1;
      bus.blink     <= 1'b0;
    end else begin
      mode_q        <= bus.btn_mode;
      up_q          <= bus.btn_up;
      down_q        <= bus.btn_down;
      state         <= nxt_state;
      bus.display   <= (nxt_state != RUN);
      bus.setup_n   <= field_enable_n(nxt_state);
      bus.field_sel <= nxt_state;
      bus.tick      <= tick_nxt;

      // Adjust: press gives an immediate tick, holding gives auto-repeat.
      if (abort) begin
        act_up    <= 1'b0;
        act_down  <= 1'b0;
        repeating <= 1'b0;
        rep_cnt   <= '0;
      end else if (press_up || press_down) begin
        bus.inc_dec <= press_up;
        act_up      <= press_up;
        act_down    <= press_down;
        repeating   <= 1'b0;
        rep_cnt     <= '0;
      end else if (hold_up || hold_down) begin
        if (rep_last) begin
          bus.inc_dec <= hold_up;
          repeating   <= 1'b1;
          rep_cnt     <= '0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else begin
        act_up    <= 1'b0;
        act_down  <= 1'b0;
        repeating <= 1'b0;
        rep_cnt   <= '0;
      end

      // Inactivity timer: any user action restarts it, RUN keeps it idle.
      if (!in_set || mode_rise || tmo_hit || tick_nxt) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + 1'b1;

      // Blink restarts visible on every field change and is dark in RUN.
      if (nxt_state != state) begin
        bus.blink <= (nxt_state != RUN);
        blink_cnt <= '0;
      end else if (!in_set) begin
        bus.blink <= 1'b0;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
        bus.blink <= ~bus.blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_setup_ctrl.sv
// Bench for clock_setup_ctrl: table-driven mode stepping plus hand-written
// hold, timeout and reset sequences, checked through an expectation queue.
module tb_clock_setup_ctrl;

  localparam int HOLD_DELAY    = 8;
  localparam int REPEAT_PERIOD = 4;
  localparam int TIMEOUT       = 64;
  localparam int BLINK_HALF    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clock_setup_ctrl_if bus ();

  clock_setup_ctrl #(
    .HOLD_DELAY    (HOLD_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .TIMEOUT       (TIMEOUT),
    .BLINK_HALF    (BLINK_HALF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       inc;
    logic [2:0] field;
    int         blink;   // -1 = not checked in SET states
  } exp_t;

  typedef struct {
    logic       m;
    logic       u;
    logic       d;
    logic       t;
    logic [2:0] f;
    int         bl;
  } vec_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_dir     = 1'b1;

  task automatic check(input string name);
    exp_t       e;
    logic [5:0] sn;
    logic       disp;
    logic       bl;
    int         bad;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard empty", name);
      miscompares++;
      return;
    end
    e    = sb.pop_front();
    disp = (e.field != 3'd0);
    sn   = (e.field == 3'd0) ? 6'b111111 : ~(6'b000001 << (e.field - 3'd1));
    bad  = 0;
    vectors++;
    if (bus.tick !== e.tick) begin
      $display("FAIL %s tick got %b want %b", name, bus.tick, e.tick); bad = 1;
    end
    if (bus.inc_dec !== e.inc) begin
      $display("FAIL %s inc_dec got %b want %b", name, bus.inc_dec, e.inc); bad = 1;
    end
    if (bus.field_sel !== e.field) begin
      $display("FAIL %s field_sel got %0d want %0d", name, bus.field_sel, e.field); bad = 1;
    end
    if (bus.display !== disp) begin
      $display("FAIL %s display got %b want %b", name, bus.display, disp); bad = 1;
    end
    if (bus.setup_n !== sn) begin
      $display("FAIL %s setup_n got %b want %b", name, bus.setup_n, sn); bad = 1;
    end
    if (e.field == 3'd0 || e.blink >= 0) begin
      bl = (e.field == 3'd0) ? 1'b0 : e.blink[0];
      if (bus.blink !== bl) begin
        $display("FAIL %s blink got %b want %b", name, bus.blink, bl); bad = 1;
      end
    end
    if (bad != 0) miscompares++;
  endtask

  task automatic expect_now(input logic t, input logic [2:0] f, input int bl);
    exp_t e;
    e.tick = t; e.inc = exp_dir; e.field = f; e.blink = bl;
    sb.push_back(e);
  endtask

  // Drive one cycle of button levels and check the outputs after the edge.
  task automatic step(input logic m, input logic u, input logic d, input logic t,
                      input logic [2:0] f, input int bl, input string name);
    @(negedge clk);
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
    if (t) exp_dir = u & ~d;
    expect_now(t, f, bl);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic pulse_mode(input logic [2:0] f);
    step(1'b1, 1'b0, 1'b0, 1'b0, f, 1, "mode_rise");
    step(1'b0, 1'b0, 1'b0, 1'b0, f, 1, "mode_release");
  endtask

  vec_t tbl[14];

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;

    // mode stepping RUN -> SEC -> MIN -> HOUR, then blink cadence in SET_HOUR
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1};

    // reset state
    #12;
    expect_now(1'b0, 3'd0, 0);
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      step(tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].t, tbl[i].f, tbl[i].bl, "t1_mode_table");

    // up held 20 cycles in SET_HOUR
    for (int j = 0; j < 20; j++)
      step(1'b0, 1'b1, 1'b0, (j == 0 || j == 8 || j == 12 || j == 16), 3'd3, -1, "t2_up_hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, -1, "t2_release");

    // through SET_YEAR to RUN; presses ignored in RUN
    pulse_mode(3'd4);
    pulse_mode(3'd5);
    pulse_mode(3'd6);
    pulse_mode(3'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 0, "t4_up_in_run");
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, "t4_release_in_run");
    pulse_mode(3'd1);
    pulse_mode(3'd2);

    // SET_MIN: single down tick, then both buttons, then mode beating up
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, -1, "t3_down_press");
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, -1, "t3_down_release");
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, -1, "t3_both");
    for (int j = 0; j < 10; j++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, -1, "t3_up_after_both");
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, -1, "t3_release");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1, "t3_mode_beats_up");
    for (int j = 0; j < 10; j++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, -1, "t3_up_after_mode");
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, -1, "t3_release2");

    // SET_DAY idle timeout
    pulse_mode(3'd4);
    for (int j = 2; j <= 64; j++)
      step(1'b0, 1'b0, 1'b0, 1'b0, (j == 64) ? 3'd0 : 3'd4, -1, "t5_timeout");

    // SET_DAY timeout pushed out by a tick at cycle 40
    pulse_mode(3'd1);
    pulse_mode(3'd2);
    pulse_mode(3'd3);
    pulse_mode(3'd4);
    for (int j = 2; j <= 104; j++)
      step(1'b0, (j == 40), 1'b0, (j == 40), (j == 104) ? 3'd0 : 3'd4, -1, "t5_tick_delays_timeout");

    // async reset mid-hold in SET_SEC
    pulse_mode(3'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, -1, "t6_press");
    for (int j = 0; j < 4; j++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, -1, "t6_hold");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_dir = 1'b1;
    expect_now(1'b0, 3'd0, 0);
    check("t6_async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 0, "t6_held_after_reset");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1, "t6_mode_with_up_held");
    for (int j = 0; j < 10; j++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, -1, "t6_no_fresh_rise");
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, -1, "t6_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
